// File: rtl/deco_salida_multicanal_pkg.sv
// deco_pkg: shared state enum, estado bit positions and port-offset helpers.
package deco_pkg;

    typedef enum logic {IDLE, BUSY} state_t;

    localparam int EST_OCUPADO  = 0;
    localparam int EST_ERR_OCUP = 1;
    localparam int EST_ERR_CMD  = 2;
    localparam int EST_ERR_TO   = 3;

    function automatic int cmd_ofs(input int num_regs);
        return num_regs;
    endfunction

    function automatic int clr_ofs(input int num_regs);
        return num_regs + 1;
    endfunction

endpackage

// File: rtl/deco_salida_multicanal_if.sv
// deco_salida_multicanal_if: PicoBlaze output bus, RTC engine handshake and decoder outputs.
interface deco_salida_multicanal_if #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 2,
    parameter int NUM_CMDS = 3
);
    logic [7:0]                 port_id;
    logic                       W_Strobe;
    logic [DATA_W-1:0]          port_out;
    logic                       listo;
    logic [NUM_REGS*DATA_W-1:0] reg_bus;
    logic [NUM_CMDS-1:0]        arranque;
    logic                       ocupado;
    logic [7:0]                 estado;

    modport master (
        output port_id, W_Strobe, port_out, listo,
        input  reg_bus, arranque, ocupado, estado
    );

    modport slave (
        input  port_id, W_Strobe, port_out, listo,
        output reg_bus, arranque, ocupado, estado
    );
endinterface

// File: rtl/deco_salida_multicanal_detector_flanco.sv
// detector_flanco: one-cycle pulse on the rising edge of i_d, however long i_d stays high.
module detector_flanco (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_flanco
);
    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_q <= 1'b0;
        else     r_q <= i_d;
    end

    assign o_flanco = i_d & ~r_q;
endmodule

// File: rtl/deco_salida_multicanal.sv
// deco_salida_multicanal: PicoBlaze output-port decoder with data registers, one-hot RTC
// start requests, busy protection, command validation, listo timeout and status byte.
module deco_salida_multicanal
    import deco_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 2,
    parameter int NUM_CMDS    = 3,
    parameter int BASE_ID     = 1,
    parameter int TIMEOUT_CYC = 1000
) (
    input logic clk,
    input logic rst,
    deco_salida_multicanal_if.slave bus
);
    localparam int              CNT_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [8:0]      CMD_OFS = 9'(cmd_ofs(NUM_REGS));
    localparam logic [8:0]      CLR_OFS = 9'(clr_ofs(NUM_REGS));

    logic                w_evt;
    logic [8:0]          w_ofs;
    logic                w_reg_hit, w_cmd_hit, w_clr_hit;
    state_t              r_state, w_state_n;
    logic [NUM_CMDS-1:0] r_arranque, w_arranque_n;
    logic [CNT_W-1:0]    r_cnt, w_cnt_n;
    logic                r_err_ocup, r_err_cmd, r_err_to;
    logic                w_err_ocup_n, w_err_cmd_n, w_err_to_n;
    logic [7:0]          w_estado;

    detector_flanco u_flanco (
        .clk     (clk),
        .rst     (rst),
        .i_d     (bus.W_Strobe),
        .o_flanco(w_evt)
    );

    // Port ids below BASE_ID wrap to >= 256 in 9 bits, so they never hit a register offset.
    assign w_ofs     = {1'b0, bus.port_id} - 9'(BASE_ID);
    assign w_reg_hit = w_evt && (w_ofs < 9'(NUM_REGS));
    assign w_cmd_hit = w_evt && (w_ofs == CMD_OFS);
    assign w_clr_hit = w_evt && (w_ofs == CLR_OFS);

    always_comb begin
        w_state_n    = r_state;
        w_arranque_n = r_arranque;
        w_cnt_n      = r_cnt;
        w_err_ocup_n = r_err_ocup & ~w_clr_hit;
        w_err_cmd_n  = r_err_cmd & ~w_clr_hit;
        w_err_to_n   = r_err_to & ~w_clr_hit;
        if (r_state == IDLE) begin
            if (w_cmd_hit && (bus.port_out < DATA_W'(NUM_CMDS))) begin
                w_state_n    = BUSY;
                w_arranque_n = NUM_CMDS'(1) << bus.port_out;
                w_cnt_n      = '0;
            end else if (w_cmd_hit) begin
                w_err_cmd_n = 1'b1;
            end
        end else begin
            if (w_cmd_hit || w_reg_hit) w_err_ocup_n = 1'b1;
            // listo is checked first so it wins over a coincident timeout
            if (bus.listo) begin
                w_state_n    = IDLE;
                w_arranque_n = '0;
            end else if ((TIMEOUT_CYC != 0) && (r_cnt == CNT_MAX)) begin
                w_state_n    = IDLE;
                w_arranque_n = '0;
                w_err_to_n   = 1'b1;
            end else begin
                w_cnt_n = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_arranque <= '0;
            r_cnt      <= '0;
            r_err_ocup <= 1'b0;
            r_err_cmd  <= 1'b0;
            r_err_to   <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_arranque <= w_arranque_n;
            r_cnt      <= w_cnt_n;
            r_err_ocup <= w_err_ocup_n;
            r_err_cmd  <= w_err_cmd_n;
            r_err_to   <= w_err_to_n;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        logic [DATA_W-1:0] r_dato;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                r_dato <= '0;
            else if (w_reg_hit && (r_state == IDLE) && (w_ofs == 9'(k)))
                r_dato <= bus.port_out;
        end
        assign bus.reg_bus[k*DATA_W +: DATA_W] = r_dato;
    end

    always_comb begin
        w_estado               = '0;
        w_estado[EST_OCUPADO]  = (r_state == BUSY);
        w_estado[EST_ERR_OCUP] = r_err_ocup;
        w_estado[EST_ERR_CMD]  = r_err_cmd;
        w_estado[EST_ERR_TO]   = r_err_to;
    end

    assign bus.arranque = r_arranque;
    assign bus.ocupado  = (r_state == BUSY);
    assign bus.estado   = w_estado;
endmodule
